// File: rtl/spi_master_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame geometry and
// a helper that sizes the shared phase/gap down-counter.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5
    } spi_state_t;

    // Defaults shared with the slave-side modules.
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_CLK_DIV = 5;
    localparam int DEF_CS_GAP  = 4;

    // Counter width able to hold both the longest phase reload
    // (2*clk_div-1, used by HOLD) and the gap reload (cs_gap-2).
    function automatic int cnt_width(input int clk_div, input int cs_gap);
        int max_v;
        max_v = (2 * clk_div > cs_gap) ? 2 * clk_div : cs_gap;
        return (max_v > 2) ? $clog2(max_v) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable half-period down-counter. restart reloads CLK_DIV-1 (one sck
// half-period), load takes an arbitrary value, and tc flags count zero.
module spi_clk_div #(
    parameter int CLK_DIV = 5,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             restart,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Down-counter: reload on request, otherwise count to zero and park.
    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!nrst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= CNT_W'(CLK_DIV - 1);
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator. Two-process FSM: a register block holding state,
// shift registers, bit counter and the registered pins, and a combinational
// block computing the next value of every one of them.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CS_GAP  = DEF_CS_GAP
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sck,
    output logic              ncs,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = cnt_width(CLK_DIV, CS_GAP);
    localparam int BCW   = $clog2(DATA_W + 1);

    // HOLD spans a trailing sck-low half-period plus the ncs hold half-period.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(2 * CLK_DIV - 1);
    // GAP covers CS_GAP-1 cycles; the first IDLE cycle completes the gap.
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);

    spi_state_t        state, state_d;
    logic [DATA_W-1:0] shift_tx, shift_tx_d, shifted_tx;
    logic [DATA_W-1:0] shift_rx, shift_rx_d;
    logic [DATA_W-1:0] rx_data_d;
    logic [BCW-1:0]    bit_cnt, bit_cnt_d;
    logic              sck_d, ncs_d, mosi_d, busy_d, done_d;
    logic              div_restart, div_load, div_tc;
    logic [CNT_W-1:0]  div_val;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_clk_div (
        .clk      (clk),
        .nrst     (nrst),
        .restart  (div_restart),
        .load     (div_load),
        .load_val (div_val),
        .tc       (div_tc)
    );

    // Register block: state, datapath and all output pins.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: shift registers are plain flops, so resetting them is cheap and keeps sim free of X.
            state    <= IDLE;
            shift_tx <= '0;
            shift_rx <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            sck      <= 1'b0;
            ncs      <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            shift_tx <= shift_tx_d;
            shift_rx <= shift_rx_d;
            bit_cnt  <= bit_cnt_d;
            rx_data  <= rx_data_d;
            sck      <= sck_d;
            ncs      <= ncs_d;
            mosi     <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next-state and next-output logic, advancing one phase per divider tc.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state;
        shift_tx_d  = shift_tx;
        shift_rx_d  = shift_rx;
        bit_cnt_d   = bit_cnt;
        rx_data_d   = rx_data;
        sck_d       = sck;
        ncs_d       = ncs;
        mosi_d      = mosi;
        busy_d      = busy;
        done_d      = 1'b0;
        div_restart = 1'b0;
        div_load    = 1'b0;
        div_val     = '0;
        shifted_tx  = shift_tx << 1;

        case (state)
            IDLE: begin
                sck_d  = 1'b0;
                ncs_d  = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d     = SETUP;
                    shift_tx_d  = tx_data;
                    mosi_d      = tx_data[DATA_W-1];
                    ncs_d       = 1'b0;
                    busy_d      = 1'b1;
                    bit_cnt_d   = '0;
                    div_restart = 1'b1;
                end
            end

            SETUP: begin
                if (div_tc) begin
                    state_d     = HIGH;
                    sck_d       = 1'b1;
                    div_restart = 1'b1;
                end
            end

            HIGH: begin
                if (div_tc) begin
                    shift_rx_d = (shift_rx << 1) | DATA_W'(miso);
                    sck_d      = 1'b0;
                    bit_cnt_d  = bit_cnt + BCW'(1);
                    if (bit_cnt != BCW'(DATA_W - 1)) begin
                        // Slave samples on the next rise; present the next bit now.
                        state_d     = LOW;
                        shift_tx_d  = shifted_tx;
                        mosi_d      = shifted_tx[DATA_W-1];
                        div_restart = 1'b1;
                    end else begin
                        state_d  = HOLD;
                        div_load = 1'b1;
                        div_val  = HOLD_LOAD;
                    end
                end
            end

            LOW: begin
                if (div_tc) begin
                    state_d     = HIGH;
                    sck_d       = 1'b1;
                    div_restart = 1'b1;
                end
            end

            HOLD: begin
                if (div_tc) begin
                    ncs_d     = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = shift_rx;
                    done_d    = 1'b1;
                    if (CS_GAP > 1) begin
                        state_d  = GAP;
                        div_load = 1'b1;
                        div_val  = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            GAP: begin
                if (div_tc) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table-driven frames on a default
// instance plus hand sequences for back-to-back, ignored start, mid-frame
// reset and a minimal DATA_W=8/CLK_DIV=1/CS_GAP=1 instance.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] tx_data;
    logic        miso;
    logic        sck, ncs, mosi, busy, done;
    logic [15:0] rx_data;

    logic       s_start;
    logic [7:0] s_tx;
    logic       s_miso;
    logic       s_sck, s_ncs, s_mosi, s_busy, s_done;
    logic [7:0] s_rx;

    logic        use_loop;
    logic        slave_bit = 1'b0;
    logic [15:0] sl_word = 16'h0000;
    int          sl_idx = 15;
    logic        sl_ncs_q = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign miso   = use_loop ? mosi : slave_bit;
    assign s_miso = s_mosi;

    spi_master dut (
        .clk     (clk),
        .nrst    (nrst),
        .start   (start),
        .tx_data (tx_data),
        .miso    (miso),
        .sck     (sck),
        .ncs     (ncs),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data)
    );

    spi_master #(
        .DATA_W  (8),
        .CLK_DIV (1),
        .CS_GAP  (1)
    ) dut_small (
        .clk     (clk),
        .nrst    (nrst),
        .start   (s_start),
        .tx_data (s_tx),
        .miso    (s_miso),
        .sck     (s_sck),
        .ncs     (s_ncs),
        .mosi    (s_mosi),
        .busy    (s_busy),
        .done    (s_done),
        .rx_data (s_rx)
    );

    // Slave model: presents MSB when ncs falls, next bit on each sck fall.
    always @(posedge ncs or negedge ncs or negedge sck) begin
        if (ncs) begin
            sl_ncs_q = 1'b1;
        end else if (sl_ncs_q) begin
            sl_ncs_q = 1'b0;
            sl_idx   = 15;
        end else if (sl_idx > 0) begin
            sl_idx = sl_idx - 1;
        end
        slave_bit = sl_word[sl_idx];
    end

    typedef struct {
        logic [15:0] tx;
        bit          loop;
        logic [15:0] slave;
        logic [15:0] exp_rx;
        bit          chk_ones;
    } vec_t;

    typedef struct {
        logic [15:0] rx;
        int          rises;
        int          ncs_low;
        int          done_at;
        int          hi_min, hi_max;
        int          lo_min, lo_max;
        int          mosi_zero;
        int          sck_bad;
        bit          timeout;
    } frame_res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    // Launch one frame on the default instance and measure it cycle by cycle.
    task automatic run_frame(input logic [15:0] tx, output frame_res_t r);
        int   cyc = 1;
        int   run = 0;
        logic prev = 1'b0;
        bit   seen = 1'b0;
        bit   got = 1'b0;
        r = '{rx: 16'h0, rises: 0, ncs_low: 0, done_at: -1, hi_min: 999, hi_max: 0,
              lo_min: 999, lo_max: 0, mosi_zero: 0, sck_bad: 0, timeout: 1'b0};
        @(negedge clk);
        tx_data = tx;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got && cyc < 1000) begin
            if (!ncs) begin
                r.ncs_low++;
                if (!mosi) r.mosi_zero++;
            end
            if (ncs && sck) r.sck_bad++;
            if (sck != prev) begin
                if (prev) begin
                    if (run < r.hi_min) r.hi_min = run;
                    if (run > r.hi_max) r.hi_max = run;
                end else if (seen) begin
                    if (run < r.lo_min) r.lo_min = run;
                    if (run > r.lo_max) r.lo_max = run;
                end
                if (sck) begin
                    r.rises++;
                    seen = 1'b1;
                end
                run = 1;
            end else begin
                run++;
            end
            prev = sck;
            if (done) begin
                got       = 1'b1;
                r.done_at = cyc;
                r.rx      = rx_data;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        r.timeout = !got;
    endtask

    vec_t       vecs[4];
    frame_res_t res;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int dones;
        int ncs_hi;
        int busy_lo;
        int rises;
        int last_rise;
        int per_min;
        int per_max;
        int s_low;
        int s_done_at;
        int s_bad;
        logic [15:0] cap;

        vecs[0] = '{16'hA5C3, 1'b1, 16'h0000, 16'hA5C3, 1'b0};
        vecs[1] = '{16'hFFFF, 1'b0, 16'h3C5A, 16'h3C5A, 1'b1};
        vecs[2] = '{16'h0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[3] = '{16'h8001, 1'b1, 16'h0000, 16'h8001, 1'b0};

        nrst     = 1'b0;
        start    = 1'b0;
        tx_data  = 16'h0;
        s_start  = 1'b0;
        s_tx     = 8'h0;
        use_loop = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_sck",  {31'b0, sck},  32'd0);
        check("rst_ncs",  {31'b0, ncs},  32'd1);
        check("rst_mosi", {31'b0, mosi}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_rx",   {16'b0, rx_data}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Table-driven frames on the default instance.
        for (int i = 0; i < 4; i++) begin
            use_loop = vecs[i].loop;
            sl_word  = vecs[i].slave;
            wait_idle();
            run_frame(vecs[i].tx, res);
            check($sformatf("v%0d_timeout", i), {31'b0, res.timeout}, 32'd0);
            check($sformatf("v%0d_rx", i),      {16'b0, res.rx}, {16'b0, vecs[i].exp_rx});
            check($sformatf("v%0d_rises", i),   res.rises, 32'd16);
            check($sformatf("v%0d_ncs_low", i), res.ncs_low, 32'd170);
            check($sformatf("v%0d_done_at", i), res.done_at, 32'd171);
            check($sformatf("v%0d_hi_min", i),  res.hi_min, 32'd5);
            check($sformatf("v%0d_hi_max", i),  res.hi_max, 32'd5);
            check($sformatf("v%0d_lo_min", i),  res.lo_min, 32'd5);
            check($sformatf("v%0d_lo_max", i),  res.lo_max, 32'd5);
            check($sformatf("v%0d_sck_ncs_hi", i), res.sck_bad, 32'd0);
            if (vecs[i].chk_ones) check($sformatf("v%0d_mosi_ones", i), res.mosi_zero, 32'd0);
        end

        // Back-to-back frames with start held high.
        use_loop = 1'b1;
        wait_idle();
        @(negedge clk);
        tx_data = 16'h0001;
        start   = 1'b1;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done1", {31'b0, done}, 32'd1);
        check("b2b_rx1", {16'b0, rx_data}, 32'h0001);
        tx_data = 16'h8000;
        ncs_hi  = 0;
        busy_lo = 0;
        n = 0;
        while (ncs && n < 50) begin
            ncs_hi++;
            if (!busy) busy_lo++;
            @(negedge clk);
            n++;
        end
        check("b2b_ncs_high", ncs_hi, 32'd4);
        check("b2b_busy_low", busy_lo, 32'd1);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("b2b_done2", {31'b0, done}, 32'd1);
        check("b2b_rx2", {16'b0, rx_data}, 32'h8000);

        // start pulsed mid-frame must be ignored.
        wait_idle();
        @(negedge clk);
        tx_data = 16'h0F0F;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        tx_data = 16'h1234;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        cap   = 16'h0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                dones++;
                cap = rx_data;
            end
            @(negedge clk);
        end
        check("ign_dones", dones, 32'd1);
        check("ign_rx", {16'b0, cap}, 32'h0F0F);

        // Reset at the 8th sck rise aborts the frame.
        wait_idle();
        @(negedge clk);
        tx_data = 16'hC3C3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0;
        n = 0;
        begin
            logic p;
            p = 1'b0;
            while (rises < 8 && n < 400) begin
                if (sck && !p) rises++;
                p = sck;
                if (rises < 8) begin
                    @(negedge clk);
                    n++;
                end
            end
        end
        check("rst8_reached", rises, 32'd8);
        nrst = 1'b0;
        #1;
        check("rst8_sck",  {31'b0, sck},  32'd0);
        check("rst8_ncs",  {31'b0, ncs},  32'd1);
        check("rst8_busy", {31'b0, busy}, 32'd0);
        check("rst8_done", {31'b0, done}, 32'd0);
        check("rst8_rx",   {16'b0, rx_data}, 32'd0);
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        nrst = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("rst8_no_done", dones, 32'd0);
        wait_idle();
        run_frame(16'h00FF, res);
        check("post_rst_rx", {16'b0, res.rx}, 32'h00FF);
        check("post_rst_rises", res.rises, 32'd16);
        check("post_rst_done_at", res.done_at, 32'd171);

        // Minimal instance: DATA_W=8, CLK_DIV=1, CS_GAP=1, loopback.
        @(negedge clk);
        s_tx    = 8'h96;
        s_start = 1'b1;
        @(negedge clk);
        s_start   = 1'b0;
        rises     = 0;
        last_rise = -1;
        per_min   = 999;
        per_max   = 0;
        s_low     = 0;
        s_done_at = -1;
        s_bad     = 0;
        begin
            logic p;
            p = 1'b0;
            for (int c = 1; c < 100 && s_done_at < 0; c++) begin
                if (!s_ncs) s_low++;
                if (s_ncs && s_sck) s_bad++;
                if (s_sck && !p) begin
                    rises++;
                    if (last_rise >= 0) begin
                        if (c - last_rise < per_min) per_min = c - last_rise;
                        if (c - last_rise > per_max) per_max = c - last_rise;
                    end
                    last_rise = c;
                end
                p = s_sck;
                if (s_done) begin
                    s_done_at = c;
                    cap = {8'h00, s_rx};
                end else begin
                    @(negedge clk);
                end
            end
        end
        check("small_done_at", s_done_at, 32'd19);
        check("small_rx", {16'b0, cap}, 32'h0096);
        check("small_rises", rises, 32'd8);
        check("small_per_min", per_min, 32'd2);
        check("small_per_max", per_max, 32'd2);
        check("small_ncs_low", s_low, 32'd18);
        check("small_sck_ncs_hi", s_bad, 32'd0);
        @(negedge clk);
        check("small_idle", {31'b0, s_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
